// File: rtl/dmi_initiator.sv
// dmi_initiator: host-side DMI requester with one transaction in flight.
// It turns local commands into DMI request/response handshakes, watches for
// response timeouts and DM busy replies, and keeps a sticky busy flag until
// a DMI reset (clear) sequence has run.
//
// Packed DMI layouts:
//   dmi_req_o  = {addr[6:0], op[1:0], data[31:0]}   (41 bits)
//   dmi_resp_i = {data[31:0], resp[1:0]}            (34 bits)
module dmi_initiator #(
  parameter int unsigned TimeoutCycles = 256,
  parameter int unsigned RstCycles     = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [6:0]  cmd_addr_i,
  input  logic [31:0] cmd_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic [1:0]  rsp_err_o,
  input  logic        dmi_clear_i,
  output logic        clear_ack_o,
  output logic        sticky_busy_o,
  output logic        dmi_rst_no,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  output logic [40:0] dmi_req_o,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  input  logic [33:0] dmi_resp_i
);

  // A zero timeout disables the watchdog; keep the counter at least 1 bit wide.
  localparam int unsigned ToW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam int unsigned RcW = $clog2(RstCycles + 1);

  localparam logic [1:0] OpRead  = 2'd1;
  localparam logic [1:0] OpWrite = 2'd2;

  localparam logic [1:0] ErrNone = 2'd0;
  localparam logic [1:0] ErrDm   = 2'd2;
  localparam logic [1:0] ErrBusy = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    DONE,
    RST
  } state_e;

  state_e          state_reg, state_next;
  logic [40:0]     req_reg, req_next;
  logic            is_read_reg, is_read_next;
  logic [31:0]     rsp_data_reg, rsp_data_next;
  logic [1:0]      rsp_err_reg, rsp_err_next;
  logic            sticky_reg, sticky_next;
  logic            clear_ack_reg, clear_ack_next;
  logic [ToW-1:0]  timeout_cnt_reg, timeout_cnt_next;
  logic [RcW-1:0]  rst_cnt_reg, rst_cnt_next;

  // Handshake flags registered from the next state so they are glitch-free.
  logic            req_valid_reg;
  logic            rsp_valid_reg;
  logic            resp_ready_reg;
  logic            dmi_rst_n_reg;

  logic [1:0]      resp_code;
  logic [31:0]     resp_data;

  assign resp_code = dmi_resp_i[1:0];
  assign resp_data = dmi_resp_i[33:2];

  // Command ready is the only combinational output; a clear request wins.
  assign cmd_ready_o = rst_ni && (state_reg == IDLE) && !dmi_clear_i;

  assign rsp_valid_o      = rsp_valid_reg;
  assign rsp_data_o       = rsp_data_reg;
  assign rsp_err_o        = rsp_err_reg;
  assign clear_ack_o      = clear_ack_reg;
  assign sticky_busy_o    = sticky_reg;
  assign dmi_rst_no       = dmi_rst_n_reg;
  assign dmi_req_valid_o  = req_valid_reg;
  assign dmi_req_o        = req_reg;
  assign dmi_resp_ready_o = resp_ready_reg;

  // Next-state, datapath and flag computation for the transaction FSM.
  always_comb begin
    state_next       = state_reg;
    req_next         = req_reg;
    is_read_next     = is_read_reg;
    rsp_data_next    = rsp_data_reg;
    rsp_err_next     = rsp_err_reg;
    sticky_next      = sticky_reg;
    clear_ack_next   = 1'b0;
    timeout_cnt_next = timeout_cnt_reg;
    rst_cnt_next     = rst_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (dmi_clear_i) begin
          state_next   = RST;
          rst_cnt_next = '0;
        end else if (cmd_valid_i) begin
          if (sticky_reg) begin
            // Refuse DMI traffic until software clears the busy condition.
            rsp_data_next = '0;
            rsp_err_next  = ErrBusy;
            state_next    = DONE;
          end else if (cmd_op_i == OpRead || cmd_op_i == OpWrite) begin
            req_next     = {cmd_addr_i, cmd_op_i, cmd_data_i};
            is_read_next = (cmd_op_i == OpRead);
            state_next   = REQ;
          end else begin
            // NOP (and the reserved op 3) completes locally.
            rsp_data_next = '0;
            rsp_err_next  = ErrNone;
            state_next    = DONE;
          end
        end
      end

      REQ: begin
        if (dmi_req_ready_i) begin
          req_next         = '0;
          timeout_cnt_next = '0;
          state_next       = RESP;
        end
      end

      RESP: begin
        if (dmi_resp_valid_i) begin
          // A response always beats a timeout that would fire this cycle.
          rsp_data_next = is_read_reg ? resp_data : 32'd0;
          case (resp_code)
            2'd0:    rsp_err_next = ErrNone;
            2'd3: begin
              rsp_err_next = ErrBusy;
              sticky_next  = 1'b1;
            end
            default: rsp_err_next = ErrDm;
          endcase
          state_next = DONE;
        end else if (TimeoutCycles != 0) begin
          if (timeout_cnt_reg == ToW'(TimeoutCycles)) begin
            rsp_data_next = '0;
            rsp_err_next  = ErrBusy;
            sticky_next   = 1'b1;
            state_next    = DONE;
          end else begin
            timeout_cnt_next = timeout_cnt_reg + ToW'(1);
          end
        end
      end

      DONE: begin
        if (rsp_ready_i) begin
          rsp_data_next = '0;
          rsp_err_next  = ErrNone;
          state_next    = IDLE;
        end
      end

      RST: begin
        // Late DM responses are simply soaked up here and dropped.
        if (rst_cnt_reg == RcW'(RstCycles - 1)) begin
          sticky_next    = 1'b0;
          clear_ack_next = 1'b1;
          state_next     = IDLE;
        end else begin
          rst_cnt_next = rst_cnt_reg + RcW'(1);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; asynchronous reset abandons any transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= IDLE;
      req_reg         <= '0;
      is_read_reg     <= 1'b0;
      rsp_data_reg    <= '0;
      rsp_err_reg     <= '0;
      sticky_reg      <= 1'b0;
      clear_ack_reg   <= 1'b0;
      timeout_cnt_reg <= '0;
      rst_cnt_reg     <= '0;
      req_valid_reg   <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      resp_ready_reg  <= 1'b0;
      dmi_rst_n_reg   <= 1'b1;
    end else begin
      state_reg       <= state_next;
      req_reg         <= req_next;
      is_read_reg     <= is_read_next;
      rsp_data_reg    <= rsp_data_next;
      rsp_err_reg     <= rsp_err_next;
      sticky_reg      <= sticky_next;
      clear_ack_reg   <= clear_ack_next;
      timeout_cnt_reg <= timeout_cnt_next;
      rst_cnt_reg     <= rst_cnt_next;
      req_valid_reg   <= (state_next == REQ);
      rsp_valid_reg   <= (state_next == DONE);
      resp_ready_reg  <= (state_next == RESP) || (state_next == RST);
      dmi_rst_n_reg   <= (state_next != RST);
    end
  end

endmodule

// File: tb/tb_dmi_initiator.sv
// tb_dmi_initiator: directed plus randomized bench for dmi_initiator.
// A transaction-level model predicts each result (error code, data, sticky
// flag, latency) from the command and the simulated DM's behaviour.
module tb_dmi_initiator;

  localparam int TO = 8;
  localparam int RC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [6:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic        dmi_clear;
  logic        clear_ack;
  logic        sticky;
  logic        dmi_rst_n;
  logic        dmi_req_valid;
  logic        dmi_req_ready;
  logic [40:0] dmi_req;
  logic        dmi_resp_valid;
  logic        dmi_resp_ready;
  logic [33:0] dmi_resp;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;
  bit sticky_m = 1'b0;
  logic [1:0] err_map [4];

  dmi_initiator #(
    .TimeoutCycles(TO),
    .RstCycles    (RC)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .cmd_valid_i     (cmd_valid),
    .cmd_ready_o     (cmd_ready),
    .cmd_op_i        (cmd_op),
    .cmd_addr_i      (cmd_addr),
    .cmd_data_i      (cmd_data),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_data_o      (rsp_data),
    .rsp_err_o       (rsp_err),
    .dmi_clear_i     (dmi_clear),
    .clear_ack_o     (clear_ack),
    .sticky_busy_o   (sticky),
    .dmi_rst_no      (dmi_rst_n),
    .dmi_req_valid_o (dmi_req_valid),
    .dmi_req_ready_i (dmi_req_ready),
    .dmi_req_o       (dmi_req),
    .dmi_resp_valid_i(dmi_resp_valid),
    .dmi_resp_ready_o(dmi_resp_ready),
    .dmi_resp_i      (dmi_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_clear_ack"}, clear_ack, 0);
    check({tag, "_sticky"}, sticky, 0);
    check({tag, "_req_valid"}, dmi_req_valid, 0);
    check({tag, "_req"}, dmi_req, 0);
    check({tag, "_resp_ready"}, dmi_resp_ready, 0);
    check({tag, "_dmi_rst_n"}, dmi_rst_n, 1);
  endtask

  // One full command: model prediction, command handshake, simulated DM, result.
  task automatic do_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wdata,
                        input int req_delay, input int resp_delay, input logic [1:0] code,
                        input logic [31:0] rdata, input int hold);
    logic        exp_dmi;
    logic [31:0] exp_data;
    logic [1:0]  exp_err;
    logic [40:0] exp_req;
    int          idx;
    bit          done;

    exp_dmi  = 1'b0;
    exp_data = '0;
    exp_err  = 2'd0;
    exp_req  = {addr, op, wdata};
    if (sticky_m) begin
      exp_err = 2'd3;
    end else if (op == 2'd1 || op == 2'd2) begin
      exp_dmi = 1'b1;
      if (resp_delay > TO) begin
        exp_err  = 2'd3;
        sticky_m = 1'b1;
      end else begin
        exp_err = err_map[code];
        if (op == 2'd1) exp_data = rdata;
        if (code == 2'd3) sticky_m = 1'b1;
      end
    end

    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = wdata;
    step();
    cmd_valid = 1'b0;
    cmd_addr  = 7'($urandom);
    cmd_data  = $urandom;

    if (exp_dmi) begin
      for (int i = 0; i < req_delay; i++) begin
        check("req_valid_hold", dmi_req_valid, 1);
        check("req_stable", dmi_req, exp_req);
        check("resp_ready_in_req", dmi_resp_ready, 0);
        // Stray response while the request is pending must be ignored.
        dmi_resp_valid = 1'b1;
        dmi_resp       = {32'hBAD0_0000 | 32'(i), 2'd3};
        step();
      end
      dmi_resp_valid = 1'b0;
      check("req_valid", dmi_req_valid, 1);
      check("req_payload", dmi_req, exp_req);
      dmi_req_ready = 1'b1;
      step();
      dmi_req_ready = 1'b0;
      check("req_dropped", dmi_req_valid, 0);
      idx  = 0;
      done = 1'b0;
      while (!done && idx < 64) begin
        check("resp_ready_in_resp", dmi_resp_ready, 1);
        dmi_resp_valid = (idx == resp_delay);
        dmi_resp       = {rdata, code};
        step();
        dmi_resp_valid = 1'b0;
        idx++;
        if (rsp_valid) done = 1'b1;
      end
      check("done_reached", done, 1);
      check("resp_latency", idx, ((resp_delay > TO) ? TO : resp_delay) + 1);
    end else begin
      check("local_rsp_valid", rsp_valid, 1);
    end

    for (int h = 0; h <= hold; h++) begin
      check("rsp_valid", rsp_valid, 1);
      check("rsp_data", rsp_data, exp_data);
      check("rsp_err", rsp_err, exp_err);
      check("sticky", sticky, sticky_m);
      check("req_quiet_in_done", dmi_req_valid, 0);
      rsp_ready = (h == hold);
      step();
    end
    rsp_ready = 1'b0;
    check("rsp_released", rsp_valid, 0);
    check("rsp_err_idle", rsp_err, 0);
    $display("txn %0d: op=%0d addr=0x%02h rsp_err=%0d rsp_data=0x%08h sticky=%0b",
             txn_no, op, addr, exp_err, exp_data, sticky);
    txn_no++;
  endtask

  // Clear sequence: dmi_rst_n low for RC cycles, ack pulse, sticky cleared.
  task automatic do_clear(input bit inject);
    int  low;
    bit  acked;
    dmi_clear = 1'b1;
    #1;
    check("cmd_ready_during_clear", cmd_ready, 0);
    step();
    dmi_clear = 1'b0;
    low   = 0;
    acked = 1'b0;
    for (int i = 0; i < 3 * RC + 4 && !acked; i++) begin
      if (clear_ack) begin
        acked = 1'b1;
        check("sticky_cleared", sticky, 0);
        check("rst_low_cycles", low, RC);
        check("rst_released", dmi_rst_n, 1);
      end else begin
        if (!dmi_rst_n) begin
          low++;
          check("resp_ready_in_rst", dmi_resp_ready, 1);
        end
        dmi_resp_valid = inject && (i == 1);
        dmi_resp       = {32'hDEAD_BEEF, 2'd0};
        step();
        dmi_resp_valid = 1'b0;
      end
    end
    check("clear_acked", acked, 1);
    sticky_m = 1'b0;
    step();
    check("ack_single_pulse", clear_ack, 0);
    check("no_rsp_after_clear", rsp_valid, 0);
    $display("txn %0d: clear inject=%0b rst_low=%0d sticky=%0b", txn_no, inject, low, sticky);
    txn_no++;
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [1:0]  r_code;
    logic [6:0]  r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    err_map        = '{2'd0, 2'd2, 2'd2, 2'd3};
    rst_n          = 1'b0;
    cmd_valid      = 1'b0;
    cmd_op         = 2'd0;
    cmd_addr       = '0;
    cmd_data       = '0;
    rsp_ready      = 1'b0;
    dmi_clear      = 1'b0;
    dmi_req_ready  = 1'b0;
    dmi_resp_valid = 1'b0;
    dmi_resp       = '0;

    step();
    step();
    check_reset_values("reset");
    rst_n = 1'b1;
    step();

    // Basic read with a two-cycle DM response.
    do_txn(2'd1, 7'h11, 32'h0, 0, 1, 2'd0, 32'h0040_0382, 0);
    // Write held off by request backpressure.
    do_txn(2'd2, 7'h10, 32'h8000_0001, 5, 0, 2'd0, 32'h1234_5678, 1);
    // DM error codes 2 and 1.
    do_txn(2'd1, 7'h04, 32'h0, 1, 2, 2'd2, 32'hCAFE_0001, 0);
    do_txn(2'd1, 7'h05, 32'h0, 0, 0, 2'd1, 32'hCAFE_0002, 0);
    // NOP and reserved op complete locally.
    do_txn(2'd0, 7'h16, 32'h0, 0, 0, 2'd0, 32'h0, 0);
    do_txn(2'd3, 7'h17, 32'h0, 0, 0, 2'd0, 32'h0, 0);
    // DM busy sets sticky; the follow-up read is refused without DMI traffic.
    do_txn(2'd1, 7'h11, 32'h0, 0, 0, 2'd3, 32'h5555_AAAA, 0);
    do_txn(2'd1, 7'h11, 32'h0, 0, 0, 2'd0, 32'h1111_1111, 0);
    do_txn(2'd0, 7'h11, 32'h0, 0, 0, 2'd0, 32'h0, 0);
    do_clear(1'b0);
    // Timeout, then clear with a late response during RST, then a clean read.
    do_txn(2'd1, 7'h11, 32'h0, 0, 40, 2'd0, 32'h2222_2222, 0);
    do_clear(1'b1);
    do_txn(2'd1, 7'h11, 32'h0, 0, 3, 2'd0, 32'h3333_3333, 0);
    // Response in exactly the timeout cycle, and one cycle too late.
    do_txn(2'd1, 7'h20, 32'h0, 2, TO, 2'd0, 32'h4444_4444, 0);
    do_txn(2'd2, 7'h21, 32'h7, 0, TO + 1, 2'd0, 32'h4444_4445, 0);
    do_clear(1'b0);

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      r_op    = 2'($urandom_range(0, 3));
      r_code  = 2'($urandom_range(0, 3));
      r_addr  = 7'($urandom);
      r_wdata = $urandom;
      r_rdata = $urandom;
      do_txn(r_op, r_addr, r_wdata, $urandom_range(0, 3), $urandom_range(0, TO + 3),
             r_code, r_rdata, $urandom_range(0, 2));
      if (sticky_m && $urandom_range(0, 2) == 0) do_clear(1'($urandom_range(0, 1)));
    end
    if (sticky_m) do_clear(1'b0);

    // Asynchronous reset in the middle of a RESP wait.
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_addr  = 7'h11;
    step();
    cmd_valid     = 1'b0;
    dmi_req_ready = 1'b1;
    step();
    dmi_req_ready = 1'b0;
    step();
    check("resp_wait_before_reset", dmi_resp_ready, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    step();
    rst_n = 1'b1;
    sticky_m = 1'b0;
    for (int k = 0; k < 5; k++) begin
      dmi_resp_valid = (k == 0);
      dmi_resp       = {32'h9999_9999, 2'd0};
      step();
      dmi_resp_valid = 1'b0;
      check("no_rsp_after_abort", rsp_valid, 0);
      check("no_req_after_abort", dmi_req_valid, 0);
    end
    $display("txn %0d: async reset during RESP, command abandoned", txn_no);
    txn_no++;
    do_txn(2'd1, 7'h12, 32'h0, 1, 1, 2'd0, 32'h0BAD_F00D, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
